brew_sequencer: RTL and testbench

- Downstream stage of the vmcoffee vending controller; consumes its COFFEE grant pulse and ERROR resource flag.
- Runs the physical brew cycle GRIND -> HEAT -> POUR through timed phases and drives grinder, heater and pump enables.
- Reports BUSY and DONE, and keeps a saturating dispensed-cup count for the service display.

---
 rtl/brew_pkg.sv | 28 ++
 rtl/brew_if.sv | 26 ++
 rtl/brew_sequencer_phase_timer.sv | 24 ++
 rtl/brew_sequencer.sv | 159 +++++++++++++++
 tb/tb_brew_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/brew_pkg.sv
// Shared types and defaults for the brew sequencer: state encoding,
// default phase durations and the phase-timer width helper.
package brew_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRIND,
        HEAT,
        POUR,
        FIN,
        ABORT
    } brew_state_t;

    localparam int DEF_GRIND_CYC = 4;
    localparam int DEF_HEAT_CYC  = 6;
    localparam int DEF_POUR_CYC  = 5;
    localparam int DEF_CUP_W     = 8;

    // Timer holds CYC-1 at most, so clog2 of the longest phase is enough.
    function automatic int timer_w(input int g, input int h, input int p);
        int m;
        m = g;
        if (h > m) m = h;
        if (p > m) m = p;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/brew_if.sv
// Request/status bundle between the vending controller (master) and the
// brew sequencer (slave).
interface brew_if
    import brew_pkg::*;
#(
    parameter int CUP_W = DEF_CUP_W
);
    logic             COFFEE;
    logic             ERROR;
    logic             GRIND;
    logic             HEAT;
    logic             PUMP;
    logic             BUSY;
    logic             DONE;
    logic [CUP_W-1:0] CUPS;

    modport master (
        output COFFEE, ERROR,
        input  GRIND, HEAT, PUMP, BUSY, DONE, CUPS
    );

    modport slave (
        input  COFFEE, ERROR,
        output GRIND, HEAT, PUMP, BUSY, DONE, CUPS
    );
endinterface

// File: rtl/brew_sequencer_phase_timer.sv
// Loadable down-counter for the brew phases; parks at zero until reloaded.
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign zero = (r_count == '0);
endmodule

// File: rtl/brew_sequencer.sv
// Brew cycle sequencer GRIND -> HEAT -> POUR with abort on resource fault.
// Optional macro BREW_QUEUE_EN adds a one-deep pending request while busy.
//
//   state | meaning
//   IDLE  | waiting for an accepted COFFEE request
//   GRIND | grinder on for GRIND_CYC cycles
//   HEAT  | heater on for HEAT_CYC cycles
//   POUR  | pump on for POUR_CYC cycles
//   FIN   | one-cycle DONE strobe, cup counted
//   ABORT | fault seen mid-brew, waits for ERROR=1
module brew_sequencer
    import brew_pkg::*;
#(
    parameter int GRIND_CYC = DEF_GRIND_CYC,
    parameter int HEAT_CYC  = DEF_HEAT_CYC,
    parameter int POUR_CYC  = DEF_POUR_CYC,
    parameter int CUP_W     = DEF_CUP_W
) (
    input  logic    clk,
    input  logic    rstn,
    brew_if.slave   bus
);
    localparam int TW = timer_w(GRIND_CYC, HEAT_CYC, POUR_CYC);
    localparam logic [TW-1:0] LD_GRIND = TW'(GRIND_CYC - 1);
    localparam logic [TW-1:0] LD_HEAT  = TW'(HEAT_CYC - 1);
    localparam logic [TW-1:0] LD_POUR  = TW'(POUR_CYC - 1);

    brew_state_t      r_state;
    brew_state_t      w_state_nxt;
    logic             w_load;
    logic [TW-1:0]    w_load_val;
    logic             w_zero;
    logic             r_grind, r_heat, r_pump, r_busy, r_done;
    logic [CUP_W-1:0] r_cups;
`ifdef BREW_QUEUE_EN
    logic             r_pending;
    logic             w_pending_nxt;
`endif

    phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        case (r_state)
            IDLE: begin
                if (bus.COFFEE && bus.ERROR) begin
                    w_state_nxt = GRIND;
                    w_load      = 1'b1;
                    w_load_val  = LD_GRIND;
                end
            end
            GRIND: begin
                if (!bus.ERROR) begin
                    w_state_nxt = ABORT;
                end else if (w_zero) begin
                    w_state_nxt = HEAT;
                    w_load      = 1'b1;
                    w_load_val  = LD_HEAT;
                end
            end
            HEAT: begin
                if (!bus.ERROR) begin
                    w_state_nxt = ABORT;
                end else if (w_zero) begin
                    w_state_nxt = POUR;
                    w_load      = 1'b1;
                    w_load_val  = LD_POUR;
                end
            end
            POUR: begin
                if (!bus.ERROR) begin
                    w_state_nxt = ABORT;
                end else if (w_zero) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
`ifdef BREW_QUEUE_EN
                if (bus.ERROR && (r_pending || bus.COFFEE)) begin
                    w_state_nxt = GRIND;
                    w_load      = 1'b1;
                    w_load_val  = LD_GRIND;
                end
`endif
            end
            ABORT: begin
                if (bus.ERROR) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef BREW_QUEUE_EN
    // FIN consumes or discards the pending request; abort always discards it.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_state == FIN || w_state_nxt == ABORT) begin
            w_pending_nxt = 1'b0;
        end else if (bus.COFFEE && (r_state == GRIND || r_state == HEAT || r_state == POUR)) begin
            w_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end
`endif

    // Outputs are registered from the next state so they align with r_state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_grind <= 1'b0;
            r_heat  <= 1'b0;
            r_pump  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cups  <= '0;
        end else begin
            r_grind <= (w_state_nxt == GRIND);
            r_heat  <= (w_state_nxt == HEAT);
            r_pump  <= (w_state_nxt == POUR);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == FIN);
            if (w_state_nxt == FIN && r_cups != '1) begin
                r_cups <= r_cups + CUP_W'(1);
            end
        end
    end

    assign bus.GRIND = r_grind;
    assign bus.HEAT  = r_heat;
    assign bus.PUMP  = r_pump;
    assign bus.BUSY  = r_busy;
    assign bus.DONE  = r_done;
    assign bus.CUPS  = r_cups;
endmodule

// File: tb/tb_brew_sequencer.sv
// Bench for brew_sequencer: elapsed-time brew model, directed scenarios,
// randomized traffic, and a 2-bit cup counter instance for saturation.
module tb_brew_sequencer;
    localparam int G = 4;
    localparam int H = 6;
    localparam int P = 5;
    localparam int T = G + H + P;

    logic clk;
    logic rstn;
    logic coffee;
    logic error;

    brew_if #(.CUP_W(8)) bus_a ();
    brew_if #(.CUP_W(2)) bus_b ();

    assign bus_a.COFFEE = coffee;
    assign bus_a.ERROR  = error;
    assign bus_b.COFFEE = coffee;
    assign bus_b.ERROR  = error;

    brew_sequencer #(.GRIND_CYC(G), .HEAT_CYC(H), .POUR_CYC(P), .CUP_W(8)) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_a.slave)
    );

    brew_sequencer #(.GRIND_CYC(G), .HEAT_CYC(H), .POUR_CYC(P), .CUP_W(2)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: brewing flag + cycles elapsed since acceptance, abort flag, cups.
    int m_b, m_a, m_e, m_cups, m_pend;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_b = 0; m_a = 0; m_e = 0; m_cups = 0; m_pend = 0;
    endtask

    task automatic model_step(input bit c, input bit er);
        if (m_b != 0) begin
            if (m_e == T) begin
`ifdef BREW_QUEUE_EN
                if (er && (m_pend != 0 || c)) m_e = 0;
                else m_b = 0;
                m_pend = 0;
`else
                m_b = 0;
`endif
            end else if (!er) begin
                m_b = 0; m_a = 1; m_pend = 0;
            end else begin
                if (c) m_pend = 1;
                m_e++;
                if (m_e == T) m_cups++;
            end
        end else if (m_a != 0) begin
            if (er) m_a = 0;
        end else if (c && er) begin
            m_b = 1; m_e = 0;
        end
    endtask

    task automatic compare_all();
        int eg, eh, ep, ed, eb;
        eg = (m_b != 0 && m_e < G) ? 1 : 0;
        eh = (m_b != 0 && m_e >= G && m_e < G + H) ? 1 : 0;
        ep = (m_b != 0 && m_e >= G + H && m_e < T) ? 1 : 0;
        ed = (m_b != 0 && m_e == T) ? 1 : 0;
        eb = (m_b != 0 || m_a != 0) ? 1 : 0;
        chk("grind_a", int'(bus_a.GRIND), eg);
        chk("heat_a",  int'(bus_a.HEAT),  eh);
        chk("pump_a",  int'(bus_a.PUMP),  ep);
        chk("done_a",  int'(bus_a.DONE),  ed);
        chk("busy_a",  int'(bus_a.BUSY),  eb);
        chk("cups_a",  int'(bus_a.CUPS),  sat(m_cups, 8));
        chk("grind_b", int'(bus_b.GRIND), eg);
        chk("heat_b",  int'(bus_b.HEAT),  eh);
        chk("pump_b",  int'(bus_b.PUMP),  ep);
        chk("done_b",  int'(bus_b.DONE),  ed);
        chk("busy_b",  int'(bus_b.BUSY),  eb);
        chk("cups_b",  int'(bus_b.CUPS),  sat(m_cups, 2));
    endtask

    // Called at a negedge: drive, clock, update model, sample at next negedge.
    task automatic cycle(input bit c, input bit er);
        coffee = c;
        error  = er;
        @(posedge clk);
        model_step(c, er);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int tg, th, tp, td, tbz;
        int cups_before;
        model_reset();
        rstn   = 1'b0;
        coffee = 1'b0;
        error  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_grind", int'(bus_a.GRIND), 0);
        chk("rst_busy",  int'(bus_a.BUSY),  0);
        chk("rst_done",  int'(bus_a.DONE),  0);
        chk("rst_cups",  int'(bus_a.CUPS),  0);
        rstn = 1'b1;
        cycle(0, 1);

        // Nominal brew with a single-cycle request.
        tg = 0; th = 0; tp = 0; td = 0; tbz = 0;
        for (int i = 0; i < 21; i++) begin
            cycle(i == 0, 1);
            tg  += int'(bus_a.GRIND);
            th  += int'(bus_a.HEAT);
            tp  += int'(bus_a.PUMP);
            td  += int'(bus_a.DONE);
            tbz += int'(bus_a.BUSY);
        end
        chk("nom_grind_cycles", tg, 4);
        chk("nom_heat_cycles",  th, 6);
        chk("nom_pump_cycles",  tp, 5);
        chk("nom_done_cycles",  td, 1);
        chk("nom_busy_cycles",  tbz, 16);
        chk("nom_cups",         int'(bus_a.CUPS), 1);

        // Fault on the third HEAT cycle.
        tp = 0; td = 0;
        cycle(1, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1);
        chk("flt_heat_on", int'(bus_a.HEAT), 1);
        cycle(0, 0);
        chk("flt_heat_off", int'(bus_a.HEAT), 0);
        chk("flt_busy",     int'(bus_a.BUSY), 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0);
            tp += int'(bus_a.PUMP);
            td += int'(bus_a.DONE);
        end
        chk("flt_abort_held", int'(bus_a.BUSY), 1);
        cycle(1, 1);
        chk("flt_exit_idle", int'(bus_a.BUSY), 0);
        chk("flt_no_pump",   tp, 0);
        chk("flt_no_done",   td, 0);
        chk("flt_cups",      int'(bus_a.CUPS), 1);

        // Request while resources are faulted.
        cycle(1, 0);
        chk("fq_grind", int'(bus_a.GRIND), 0);
        chk("fq_busy",  int'(bus_a.BUSY),  0);
        cycle(0, 1);

        // Request during POUR.
        cycle(1, 1);
        for (int i = 0; i < 11; i++) cycle(0, 1);
        chk("bq_in_pour", int'(bus_a.PUMP), 1);
        cycle(1, 1);
        for (int i = 0; i < 25; i++) cycle(0, 1);
`ifdef BREW_QUEUE_EN
        chk("bq_cups", int'(bus_a.CUPS), 3);
`else
        chk("bq_cups", int'(bus_a.CUPS), 2);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) != 0);
        end
        for (int i = 0; i < 20; i++) cycle(0, 1);

        // Saturation on the 2-bit instance after a fresh reset.
        rstn = 1'b0;
        model_reset();
        #1;
        chk("sat_rst_cups", int'(bus_b.CUPS), 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int b = 0; b < 5; b++) begin
            cycle(1, 1);
            for (int i = 0; i < T; i++) cycle(0, 1);
            chk("sat_done", int'(bus_b.DONE), 1);
            chk("sat_cups", int'(bus_b.CUPS), (b < 3) ? b + 1 : 3);
            cycle(0, 1);
        end
        cups_before = int'(bus_a.CUPS);
        chk("sat_wide_cups", cups_before, 5);

        // Asynchronous reset in the middle of POUR.
        cycle(1, 1);
        for (int i = 0; i < 12; i++) cycle(0, 1);
        chk("ar_pump_before", int'(bus_a.PUMP), 1);
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("ar_pump", int'(bus_a.PUMP), 0);
        chk("ar_busy", int'(bus_a.BUSY), 0);
        chk("ar_cups", int'(bus_a.CUPS), 0);
        chk("ar_pump_b", int'(bus_b.PUMP), 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 1);
        chk("ar_idle_busy", int'(bus_a.BUSY), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
